// File: rtl/reg_pc.sv
// reg_pc: two-half program counter with per-half load, carry-linked increment,
// optional one-cycle deferred carry into the high half, and registered bus capture.
module reg_pc #(
  parameter int BYTE_W = 8,
  parameter logic [2*BYTE_W-1:0] RESET_VECTOR = 16'hFFFC,
  parameter bit DEFERRED_CARRY = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                INC,
  input  logic                LOAD_L,
  input  logic [BYTE_W-1:0]   ADL_IN,
  input  logic                LOAD_H,
  input  logic [BYTE_W-1:0]   ADH_IN,
  input  logic                DB_L_EN,
  input  logic                DB_H_EN,
  input  logic                ADL_EN,
  input  logic                ADH_EN,
  output logic [BYTE_W-1:0]   DB_BUS,
  output logic [BYTE_W-1:0]   ADL_BUS,
  output logic [BYTE_W-1:0]   ADH_BUS,
  output logic [2*BYTE_W-1:0] PC_LOOP,
  output logic                CARRY_PEND,
  output logic                WRAP
);
  logic [BYTE_W-1:0] pcl, pch, pcl_nxt, pch_nxt;
  logic carry, inc_h, pend_nxt;
  // In deferred mode the high half consumes last cycle's carry; a pending carry
  // never meets a new one because PCL is zero right after a carry.
  always_comb begin
    carry = !LOAD_L && INC && (&pcl);
    inc_h = !LOAD_H && (DEFERRED_CARRY ? CARRY_PEND : carry);
    pend_nxt = DEFERRED_CARRY && !LOAD_H && !CARRY_PEND && carry;
    pcl_nxt = LOAD_L ? ADL_IN : INC ? pcl + 1'b1 : pcl;
    pch_nxt = LOAD_H ? ADH_IN : inc_h ? pch + 1'b1 : pch;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      {pch, pcl} <= RESET_VECTOR;
      DB_BUS <= '0;
      ADL_BUS <= '0;
      ADH_BUS <= '0;
      CARRY_PEND <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      pcl <= pcl_nxt;
      pch <= pch_nxt;
      CARRY_PEND <= pend_nxt;
      WRAP <= inc_h && (&pch);
      DB_BUS <= DB_L_EN ? pcl : DB_H_EN ? pch : DB_BUS;
      ADL_BUS <= ADL_EN ? pcl : ADL_BUS;
      ADH_BUS <= ADH_EN ? pch : ADH_BUS;
    end
  assign PC_LOOP = {pch, pcl};
endmodule

// File: doc/reg_pc.md
Name: reg_PC

Overview:
- Full program counter for the CPU datapath: a parametrised successor to the single-byte PCL register, holding both the low (PCL) and high (PCH) halves.
- Supports per-half parallel load from the ADL/ADH buses, increment with low-to-high carry, and an optional deferred-carry mode (6502-style page-cross fix-up cycle).
- Drives DB, ADL and ADH through registered output ports.
- The PC_LOOP output feeds the incrementer/address logic.

Parameters:
- BYTE_W, 8, width of each half (PCL, PCH) and of every bus.
- RESET_VECTOR, 16'hFFFC, PC value after reset, 2*BYTE_W bits; low half goes to PCL, high half to PCH.
- DEFERRED_CARRY, 0, 0 = PCL carry applied to PCH on the same edge; 1 = carry applied on the following edge.

Ports:
- CLK  in  1  clock, rising edge active.
- RST  in  1  reset, asynchronous, active-high.
- INC  in  1  increment PC this cycle.
- LOAD_L  in  1  load PCL from ADL_IN.
- ADL_IN  in  BYTE_W  low-byte load data.
- LOAD_H  in  1  load PCH from ADH_IN.
- ADH_IN  in  BYTE_W  high-byte load data.
- DB_L_EN  in  1  capture PCL onto DB_BUS.
- DB_H_EN  in  1  capture PCH onto DB_BUS.
- ADL_EN  in  1  capture PCL onto ADL_BUS.
- ADH_EN  in  1  capture PCH onto ADH_BUS.
- DB_BUS  out  BYTE_W  registered data-bus output.
- ADL_BUS  out  BYTE_W  registered address-low output.
- ADH_BUS  out  BYTE_W  registered address-high output.
- PC_LOOP  out  2*BYTE_W  {PCH,PCL}, loopback to incrementer.
- CARRY_PEND  out  1  deferred carry waiting (DEFERRED_CARRY=1 only, else constant 0).
- WRAP  out  1  one-cycle pulse: PC wrapped from all-ones to zero.

Behaviour:
Reset and loopback
- Clock is CLK; reset is RST, asynchronous and active-high.
- On RST: {PCH,PCL} <= RESET_VECTOR; DB_BUS, ADL_BUS, ADH_BUS <= 0; CARRY_PEND <= 0; WRAP <= 0.
- PC_LOOP is combinational {PCH,PCL}: it reflects the register state, zero added latency.

Low half (per rising edge)
- LOAD_L=1: PCL <= ADL_IN. INC is ignored for PCL and no carry is generated.
- LOAD_L=0 and INC=1: PCL <= PCL+1 mod 2^BYTE_W. A carry is generated iff old PCL is all-ones.
- Otherwise PCL holds.

High half, DEFERRED_CARRY=0
- LOAD_H=1: PCH <= ADH_IN; any carry is discarded.
- Otherwise, if carry: PCH <= PCH+1.
- Otherwise PCH holds.

High half, DEFERRED_CARRY=1
- LOAD_H=1: PCH <= ADH_IN and CARRY_PEND <= 0. Load beats a pending or new carry.
- Else if CARRY_PEND=1: PCH <= PCH+1 and CARRY_PEND <= 0. This happens independent of INC.
- Else if carry: CARRY_PEND <= 1 and PCH holds.
- Pending and new carry cannot coincide: PCL is 0 after a carry, so the next increment gives no carry. The bench asserts this.
- PCL keeps updating normally while CARRY_PEND=1.

WRAP
- Registered pulse, high for exactly one cycle after the edge on which PCH increments from all-ones to 0 due to carry, with no LOAD_H.
- Never asserted by loads.

Bus capture
- On each rising edge, each bus register captures the current (pre-update) half when its enable is high; otherwise it holds its last value.
- DB_L_EN and DB_H_EN both high: DB_BUS captures PCL (low wins).
- Enables do not affect PC state.
- Reset mid-operation clears any pending carry and any WRAP pulse immediately.

Test Plan:
1. Reset: RST=1 -> PC_LOOP=FFFC, all buses 00, CARRY_PEND=0. Release RST, INC for 4 edges -> FFFC, FFFD, FFFE, FFFF, then 0000 with WRAP=1 for exactly one cycle.
2. Load/capture: LOAD_L=1 ADL_IN=AA, LOAD_H=1 ADH_IN=12 -> PC_LOOP=12AA. Then DB_L_EN=1 for one edge -> DB_BUS=AA, held after enable drops. Then ADH_EN=1 -> ADH_BUS=12. Then DB_L_EN=DB_H_EN=1 -> DB_BUS=AA.
3. Immediate carry (DEFERRED_CARRY=0): PC=12FF, INC -> 1300 on one edge, CARRY_PEND=0.
4. Deferred carry (DEFERRED_CARRY=1): PC=12FF, INC -> 1200 with CARRY_PEND=1. Next edge with INC=0 -> 1300, CARRY_PEND=0. Repeat with INC=1 on the second edge -> 1301.
5. Priority: PC=12FF, INC=1 with LOAD_H=1 ADH_IN=40 -> 4000, no pending. INC=1 with LOAD_L=1 ADL_IN=55 -> PCL=55, PCH unchanged.
6. Async reset mid-pending (DEFERRED_CARRY=1): PC=12FF, INC -> CARRY_PEND=1. Assert RST between edges -> PC_LOOP=FFFC and CARRY_PEND=0 immediately, before the next CLK edge.
